button_pulse_conditioner: RTL and testbench

- Upstream stage of the two-input Moore FSM (inputs inA/inB, outputs OutA/OutB).
- Converts two raw, bouncy, asynchronous push-button signals into clean, debounced, single-cycle pulses.
- Those pulses drive the FSM's inA/inB, so each physical press advances the FSM by exactly one transition.
- Also exports debounced levels for LEDs and diagnostics.

---
 rtl/button_pulse_conditioner_pkg.sv | 18 +
 rtl/button_pulse_conditioner_if.sv | 14 +
 rtl/button_pulse_conditioner_debounce_ch.sv | 83 ++++++++
 rtl/button_pulse_conditioner.sv | 61 ++++++
 tb/tb_button_pulse_conditioner.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/button_pulse_conditioner_pkg.sv
// Shared types and constants for the push-button pulse conditioner.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } ch_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 12000;
  localparam int unsigned CNT_W_DEF           = 16;
  localparam int unsigned SYNC_STAGES_DEF     = 2;

  localparam int unsigned SIMUL_BOTH   = 0;
  localparam int unsigned SIMUL_A_WINS = 1;

endpackage

// File: rtl/button_pulse_conditioner_if.sv
// Raw button inputs and conditioned pulse/level outputs for both channels.
interface button_pulse_conditioner_if;
  logic btnA_raw;
  logic btnB_raw;
  logic inA;
  logic inB;
  logic levelA;
  logic levelB;

  modport master (output btnA_raw, output btnB_raw,
                  input  inA, input inB, input levelA, input levelB);
  modport slave  (input  btnA_raw, input btnB_raw,
                  output inA, output inB, output levelA, output levelB);
endinterface

// File: rtl/button_pulse_conditioner_debounce_ch.sv
// One button channel: synchronizer, stability counter and press/release FSM.
module btn_debounce_ch
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse_c,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  ch_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;

  assign s     = sync_q[SYNC_STAGES-1];
  assign level = level_q;

  // State register; level is registered from the next state so it moves with the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Next state: a change is accepted only after DEBOUNCE_CYCLES stable samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_c = 1'b0;
    case (state_q)
      S_LOW: begin
        if (s) begin
          state_d = S_RISE;
          cnt_d   = '0;
        end
      end
      S_RISE: begin
        if (!s) begin
          state_d = S_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          pulse_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!s) begin
          state_d = S_FALL;
          cnt_d   = '0;
        end
      end
      S_FALL: begin
        if (s) begin
          state_d = S_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
    level_d = (state_d == S_HIGH) || (state_d == S_FALL);
  end

endmodule

// File: rtl/button_pulse_conditioner.sv
// Two debounced button channels with optional A-over-B arbitration of same-cycle pulses.
module button_pulse_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned SIMUL_MODE      = SIMUL_BOTH
) (
  input  logic                        clk,
  input  logic                        reset,
  button_pulse_conditioner_if.slave   btn
);

  logic pulse_a_c, pulse_b_c, pulse_b_arb_c;
  logic level_a, level_b;
  logic in_a_q, in_b_q;

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_ch_a (
    .clk     (clk),
    .reset   (reset),
    .raw     (btn.btnA_raw),
    .pulse_c (pulse_a_c),
    .level   (level_a)
  );

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_ch_b (
    .clk     (clk),
    .reset   (reset),
    .raw     (btn.btnB_raw),
    .pulse_c (pulse_b_c),
    .level   (level_b)
  );

  // In A-wins mode a coincident B pulse is dropped, not deferred.
  assign pulse_b_arb_c = pulse_b_c & ~((SIMUL_MODE == SIMUL_A_WINS) & pulse_a_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_a_q <= 1'b0;
      in_b_q <= 1'b0;
    end else begin
      in_a_q <= pulse_a_c;
      in_b_q <= pulse_b_arb_c;
    end
  end

  assign btn.inA    = in_a_q;
  assign btn.inB    = in_b_q;
  assign btn.levelA = level_a;
  assign btn.levelB = level_b;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Bench for button_pulse_conditioner: table vectors, corner sequences and randomized run vs. a run-length model.
module tb_button_pulse_conditioner;
  import btn_cond_pkg::*;

  localparam int unsigned DC = 4;
  localparam int unsigned SS = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  button_pulse_conditioner_if bus0 ();
  button_pulse_conditioner_if bus1 ();

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES (DC), .CNT_W (16), .SYNC_STAGES (SS), .SIMUL_MODE (SIMUL_BOTH)
  ) dut0 (.clk (clk), .reset (reset), .btn (bus0.slave));

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES (DC), .CNT_W (16), .SYNC_STAGES (SS), .SIMUL_MODE (SIMUL_A_WINS)
  ) dut1 (.clk (clk), .reset (reset), .btn (bus1.slave));

  int checks = 0;
  int errors = 0;

  // Reference model: raw samples delayed by the synchronizer depth, then a level
  // toggles once DC+1 consecutive samples disagree with it; pulse on a rising toggle.
  bit [SS-1:0] hist_a, hist_b;
  bit lv_a, lv_b, p_a, p_b;
  int run_a, run_b;
  int npulse_a0, npulse_b0;

  function automatic void ch_model(input bit s, inout bit lv, inout int run, output bit p);
    p = 1'b0;
    if (s != lv) run++;
    else run = 0;
    if (run == int'(DC) + 1) begin
      lv  = !lv;
      run = 0;
      p   = lv;
    end
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit a, input bit b, input bit r);
    bit s_a, s_b;
    bus0.btnA_raw = a; bus0.btnB_raw = b;
    bus1.btnA_raw = a; bus1.btnB_raw = b;
    reset = r;
    @(posedge clk);
    if (r) begin
      hist_a = '0; hist_b = '0;
      lv_a = 1'b0; lv_b = 1'b0; run_a = 0; run_b = 0; p_a = 1'b0; p_b = 1'b0;
    end else begin
      s_a = hist_a[SS-1];
      s_b = hist_b[SS-1];
      hist_a = {hist_a[SS-2:0], a};
      hist_b = {hist_b[SS-2:0], b};
      ch_model(s_a, lv_a, run_a, p_a);
      ch_model(s_b, lv_b, run_b, p_b);
    end
    #1;
    chk("m0_inA", bus0.inA, p_a);
    chk("m0_inB", bus0.inB, p_b);
    chk("m0_levelA", bus0.levelA, lv_a);
    chk("m0_levelB", bus0.levelB, lv_b);
    chk("m1_inA", bus1.inA, p_a);
    chk("m1_inB", bus1.inB, p_b & ~p_a);
    chk("m1_levelA", bus1.levelA, lv_a);
    chk("m1_levelB", bus1.levelB, lv_b);
    npulse_a0 += int'(bus0.inA);
    npulse_b0 += int'(bus0.inB);
  endtask

  typedef struct {
    bit a, b, r;
    bit e_in_a, e_in_b, e_lv_a, e_lv_b;
  } vec_t;

  vec_t tbl[13];
  bit cur_a, cur_b;

  initial begin
    // Reset held 3 cycles with both buttons high, then a clean press of A.
    for (int i = 0; i < 3; i++) tbl[i] = '{1, 1, 1, 0, 0, 0, 0};
    for (int i = 3; i < 13; i++) tbl[i] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 1, 0, 1, 0};
    tbl[10] = '{1, 0, 0, 0, 0, 1, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 1, 0};
    tbl[12] = '{1, 0, 0, 0, 0, 1, 0};

    bus0.btnA_raw = 1'b0; bus0.btnB_raw = 1'b0;
    bus1.btnA_raw = 1'b0; bus1.btnB_raw = 1'b0;
    reset = 1'b1;
    npulse_a0 = 0; npulse_b0 = 0;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].a, tbl[i].b, tbl[i].r);
      chk($sformatf("tbl%0d_inA", i), bus0.inA, tbl[i].e_in_a);
      chk($sformatf("tbl%0d_inB", i), bus0.inB, tbl[i].e_in_b);
      chk($sformatf("tbl%0d_levelA", i), bus0.levelA, tbl[i].e_lv_a);
      chk($sformatf("tbl%0d_levelB", i), bus0.levelB, tbl[i].e_lv_b);
    end

    // Long hold, then release with bounce 0,1,0: no second pulse, level falls 6 edges after final 0.
    npulse_a0 = 0;
    for (int i = 0; i < 40; i++) step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("release_level_still_high", bus0.levelA, 1'b1);
    step(0, 0, 0);
    chk("release_level_low", bus0.levelA, 1'b0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("release_no_pulse", logic'(npulse_a0 == 0), 1'b1);

    // Press bounce 1,0,1,0 then low: rejected.
    step(1, 0, 0); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    chk("bounce_no_pulse", logic'(npulse_a0 == 0), 1'b1);
    chk("bounce_level_low", bus0.levelA, 1'b0);

    // Simultaneous press on both buttons.
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 0);
    step(1, 1, 0);
    chk("simul0_inA", bus0.inA, 1'b1);
    chk("simul0_inB", bus0.inB, 1'b1);
    chk("simul1_inA", bus1.inA, 1'b1);
    chk("simul1_inB_dropped", bus1.inB, 1'b0);
    chk("simul1_levelB", bus1.levelB, 1'b1);
    for (int i = 0; i < 5; i++) step(0, 0, 0);

    // Reset mid-qualification while A stays high: one pulse after full latency from deassertion.
    step(0, 0, 1);
    for (int i = 0; i < 30; i++) step(0, 0, 0);
    npulse_a0 = 0;
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    step(1, 0, 1);
    chk("rst_mid_no_pulse_before", logic'(npulse_a0 == 0), 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 0);
      chk($sformatf("rst_mid_wait%0d", k), bus0.inA, 1'b0);
    end
    step(1, 0, 0);
    chk("rst_mid_pulse", bus0.inA, 1'b1);
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    chk("rst_mid_one_pulse", logic'(npulse_a0 == 1), 1'b1);

    // Randomized buttons with runs of varying length, coincident edges and rare resets.
    cur_a = 1'b0; cur_b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        cur_a = !cur_a;
        if ($urandom_range(0, 2) == 0) cur_b = cur_a;
      end
      if ($urandom_range(0, 7) == 0) cur_b = !cur_b;
      step(cur_a, cur_b, $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
